cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined successor to the team's fixed 64-bit carry-lookahead adder.
- Operand width is split into SEG-bit segments; each pipeline stage resolves one segment with a combinational CLA, and the carry is registered into the next stage.
- Adds add/subtract mode, borrow-in, flags and a valid/ready handshake with backpressure.
- Serves as the accumulate datapath of the add-shift multiplier and as a general ALU adder.

Parameters:
- WIDTH, 64: operand/result width. Must be a multiple of SEG.
- SEG, 16: segment width per stage, one of 4/8/16/32.
- NSTG, WIDTH/SEG: derived stage count, equal to the latency. Not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- CIN  in  1  carry-in (add) / borrow-in (sub).
- SUB  in  1  0 = A+B+CIN; 1 = A-B-CIN.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  sum/difference.
- COUT  out  1  carry out of the MSB. For SUB, 1 = no borrow.
- OVF  out  1  two's-complement signed overflow.
- ZERO  out  1  S == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valid bits 0, out_valid 0, S 0, COUT 0, OVF 0, ZERO 0. in_ready is 1 in the first cycle after rst deasserts.
- Operand conditioning at entry:
  - B' = SUB ? ~B : B.
  - c0 = CIN ^ SUB, so SUB=1 computes A + ~B + 1 - CIN.
- Stage k (0..NSTG-1):
  - Computes sum bits [k*SEG +: SEG] from A, B' and the registered carry c_k.
  - Registers c_{k+1}, the completed lower sum bits, and the still-unprocessed upper A/B' bits.
  - Carry leaves one stage per cycle; there is no full-width combinational carry path.
- Final stage registers S, COUT and the flags:
  - OVF = (A[MSB] == B'[MSB]) && (S[MSB] != A[MSB]).
  - ZERO is computed from the final S.
- Latency: exactly NSTG cycles from an accepted input to out_valid, with no stalls.
- Throughput: 1 beat/cycle when out_ready is held high.
- Handshake and advance:
  - adv = !out_valid || out_ready; in_ready = adv.
  - When adv=0, every stage register holds, including bubbles (global stall, no bubble collapse).
  - Input is accepted iff in_valid && in_ready. A/B/SUB/CIN are sampled only on acceptance.
  - out_valid stays high, and S/COUT/OVF/ZERO stay stable, until out_ready is seen.
  - Results emerge strictly in acceptance order, with no loss or duplication.
- Simultaneous accept and output: allowed in the same cycle; the pipeline shifts by one.
- Reset mid-operation: rst overrides adv. All in-flight beats are discarded and nothing is emitted afterwards.
- Wrap-around: modular arithmetic; COUT carries the out-of-range bit.
- NSTG=1: degenerates to a registered single-cycle adder with the same handshake.

Decomposition:
- Package cla_pkg:
  - Legal SEG values.
  - Function computing NSTG.
  - A function for the OVF expression.
- Sub-module cla_seg (SEG-bit combinational CLA: A, B, CIN -> S, GG, PG), instantiated once per stage via generate.
- Stage registers and handshake control live in cla_pipe_adder.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0 and S=0 throughout; in_ready=1 the cycle after rst falls.
- Cross-segment carry (WIDTH=64, SEG=16): A=0x0000_0000_FFFF_FFFF, B=1, SUB=0, CIN=0 -> exactly 4 cycles later S=0x0000_0001_0000_0000, COUT=0, OVF=0, ZERO=0.
- Subtract/borrow: A=5, B=7, SUB=1, CIN=0 -> S=0xFFFF_FFFF_FFFF_FFFE, COUT=0, OVF=0; then A=7, B=7, SUB=1, CIN=0 -> S=0, ZERO=1, COUT=1.
- Overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, SUB=0 -> S=0x8000_0000_0000_0000, OVF=1, COUT=0. Also A=B=0xFFFF_FFFF_FFFF_FFFF, SUB=0 -> S=0xFFFF_FFFF_FFFF_FFFE, COUT=1, OVF=0.
- Backpressure: 16 random back-to-back beats while out_ready follows a 1,0,0,1 pattern -> results match the reference model in order, outputs stable while stalled, no drops. With out_ready=1, one result per cycle.
- Mid-flight reset, with parameter sweep (SEG=8 and SEG=32): accept 3 beats, assert rst for 1 cycle before any emerge -> no out_valid afterwards. Repeat the carry test to confirm latencies of 8 and 2 respectively.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the segmented pipelined carry-lookahead adder.
package cla_pkg;

  localparam int SEG_LEGAL [4] = '{4, 8, 16, 32};

  function automatic bit seg_is_legal(input int seg);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ok = ok | (SEG_LEGAL[i] == seg);
    end
    return ok;
  endfunction

  // An illegal WIDTH/SEG pair yields zero stages, which breaks elaboration on purpose.
  function automatic int calc_nstg(input int width, input int seg);
    return (seg_is_legal(seg) && ((width % seg) == 0)) ? (width / seg) : 0;
  endfunction

  function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
interface cla_pipe_adder_if
  import cla_pkg::*;
#(
  parameter int WIDTH = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             COUT;
  logic             OVF;
  logic             ZERO;

  modport master (
    output in_valid, A, B, CIN, SUB, out_ready,
    input  in_ready, out_valid, S, COUT, OVF, ZERO
  );

  modport slave (
    input  in_valid, A, B, CIN, SUB, out_ready,
    output in_ready, out_valid, S, COUT, OVF, ZERO
  );
endinterface

// File: rtl/cla_seg.sv
// SEG-bit combinational carry-lookahead segment with group generate/propagate.
module cla_seg
  import cla_pkg::*;
#(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_s,
  output logic           o_gg,
  output logic           o_pg
);
  localparam int LVLS = $clog2(SEG);

  logic [SEG-1:0] w_g;
  logic [SEG-1:0] w_p;
  logic [SEG-1:0] w_gp;
  logic [SEG-1:0] w_pp;
  logic [SEG-1:0] w_c;

  // Kogge-Stone prefix; descending update keeps reads at the previous level.
  always_comb begin
    int d;
    w_g  = i_a & i_b;
    w_p  = i_a ^ i_b;
    w_gp = w_g;
    w_pp = w_p;
    for (int l = 0; l < LVLS; l++) begin
      d = 1 << l;
      for (int i = SEG - 1; i >= d; i--) begin
        w_gp[i] = w_gp[i] | (w_pp[i] & w_gp[i-d]);
        w_pp[i] = w_pp[i] & w_pp[i-d];
      end
    end
    w_c[0] = i_cin;
    for (int i = 1; i < SEG; i++) begin
      w_c[i] = w_gp[i-1] | (w_pp[i-1] & i_cin);
    end
    o_s  = w_p ^ w_c;
    o_gg = w_gp[SEG-1];
    o_pg = w_pp[SEG-1];
  end
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract: one SEG-bit segment resolved per stage, carry registered
// between stages, global stall on backpressure.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input logic             clk,
  input logic             rst,
  cla_pipe_adder_if.slave bus
);
  localparam int NSTG = calc_nstg(WIDTH, SEG);

  logic             r_vld [NSTG];
  logic [WIDTH-1:0] r_a   [NSTG];
  logic [WIDTH-1:0] r_b   [NSTG];
  logic [WIDTH-1:0] r_s   [NSTG];
  logic             r_c   [NSTG];
  logic             r_ovf;
  logic             r_zero;

  logic             w_adv;
  logic             w_vld_in [NSTG];
  logic [WIDTH-1:0] w_a_in   [NSTG];
  logic [WIDTH-1:0] w_b_in   [NSTG];
  logic [WIDTH-1:0] w_s_in   [NSTG];
  logic [WIDTH-1:0] w_s_out  [NSTG];
  logic             w_c_in   [NSTG];
  logic             w_c_out  [NSTG];
  logic [SEG-1:0]   w_sum    [NSTG];
  logic             w_gg     [NSTG];
  logic             w_pg     [NSTG];

  assign w_adv = ~r_vld[NSTG-1] | bus.out_ready;

  // Stage inputs: stage 0 takes the conditioned operands, later stages their predecessor.
  always_comb begin
    w_vld_in[0] = bus.in_valid;
    w_a_in[0]   = bus.A;
    w_b_in[0]   = bus.SUB ? ~bus.B : bus.B;
    w_c_in[0]   = bus.CIN ^ bus.SUB;
    w_s_in[0]   = {WIDTH{1'b0}};
    for (int k = 1; k < NSTG; k++) begin
      w_vld_in[k] = r_vld[k-1];
      w_a_in[k]   = r_a[k-1];
      w_b_in[k]   = r_b[k-1];
      w_c_in[k]   = r_c[k-1];
      w_s_in[k]   = r_s[k-1];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    cla_seg #(.SEG(SEG)) u_seg (
      .i_a   (w_a_in[k][k*SEG +: SEG]),
      .i_b   (w_b_in[k][k*SEG +: SEG]),
      .i_cin (w_c_in[k]),
      .o_s   (w_sum[k]),
      .o_gg  (w_gg[k]),
      .o_pg  (w_pg[k])
    );
  end

  // Merge each segment's sum into the running result and form its carry-out.
  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      w_s_out[k]                = w_s_in[k];
      w_s_out[k][k*SEG +: SEG]  = w_sum[k];
      w_c_out[k]                = w_gg[k] | (w_pg[k] & w_c_in[k]);
    end
  end

  // Stage registers: whole pipe shifts on adv; data only loads behind a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= {WIDTH{1'b0}};
        r_b[k]   <= {WIDTH{1'b0}};
        r_s[k]   <= {WIDTH{1'b0}};
        r_c[k]   <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < NSTG; k++) begin
        r_vld[k] <= w_vld_in[k];
        if (w_vld_in[k]) begin
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
          r_s[k] <= w_s_out[k];
          r_c[k] <= w_c_out[k];
        end
      end
      if (w_vld_in[NSTG-1]) begin
        r_ovf  <= calc_ovf(w_a_in[NSTG-1][WIDTH-1], w_b_in[NSTG-1][WIDTH-1],
                           w_s_out[NSTG-1][WIDTH-1]);
        r_zero <= (w_s_out[NSTG-1] == {WIDTH{1'b0}});
      end
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[NSTG-1];
  assign bus.S         = r_s[NSTG-1];
  assign bus.COUT      = r_c[NSTG-1];
  assign bus.OVF       = r_ovf;
  assign bus.ZERO      = r_zero;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at SEG=16, 8 and 32 sharing one stimulus.
module tb_cla_pipe_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        tb_in_valid, tb_cin, tb_sub, tb_out_ready;
  logic [63:0] tb_a, tb_b;
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(64)) if16 ();
  cla_pipe_adder_if #(.WIDTH(64)) if8 ();
  cla_pipe_adder_if #(.WIDTH(64)) if32 ();

  assign if16.in_valid = tb_in_valid;  assign if8.in_valid = tb_in_valid;  assign if32.in_valid = tb_in_valid;
  assign if16.A = tb_a;                assign if8.A = tb_a;                assign if32.A = tb_a;
  assign if16.B = tb_b;                assign if8.B = tb_b;                assign if32.B = tb_b;
  assign if16.CIN = tb_cin;            assign if8.CIN = tb_cin;            assign if32.CIN = tb_cin;
  assign if16.SUB = tb_sub;            assign if8.SUB = tb_sub;            assign if32.SUB = tb_sub;
  assign if16.out_ready = tb_out_ready; assign if8.out_ready = tb_out_ready; assign if32.out_ready = tb_out_ready;

  cla_pipe_adder #(.WIDTH(64), .SEG(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
  cla_pipe_adder #(.WIDTH(64), .SEG(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  cla_pipe_adder #(.WIDTH(64), .SEG(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

  // Reference: {OVF, COUT, S} straight from the arithmetic definition.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic sub, input logic cin);
    logic [63:0] bp;
    logic [64:0] sum;
    bp  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bp} + {64'd0, cin ^ sub};
    return {(a[63] == bp[63]) && (sum[63] != a[63]), sum};
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    tb_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic sub,
                         input logic cin, output logic [63:0] s, output logic cout,
                         output logic ovf, output logic zero, output int lat);
    tb_a = a; tb_b = b; tb_sub = sub; tb_cin = cin;
    tb_in_valid = 1'b1; tb_out_ready = 1'b1;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    lat = 1;
    while (!if16.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = if16.S; cout = if16.COUT; ovf = if16.OVF; zero = if16.ZERO;
  endtask

  task automatic test_reset;
    rst = 1'b1; tb_in_valid = 1'b1; tb_out_ready = 1'b1;
    tb_a = 64'hFFFF_FFFF_FFFF_FFFF; tb_b = 64'd1; tb_sub = 1'b0; tb_cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (if16.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", i, if16.out_valid); end
      n_cmp++;
      if (if16.S !== 64'd0) begin n_fail++; $display("FAIL reset_s cyc%0d: got %h want 0", i, if16.S); end
    end
    rst = 1'b0; tb_in_valid = 1'b0;
    n_cmp++;
    if (if16.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", if16.in_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0 || if16.COUT !== 1'b0 || if16.OVF !== 1'b0 || if16.ZERO !== 1'b0)
      begin n_fail++; $display("FAIL reset_idle: rdy=%b vld=%b cout=%b ovf=%b zero=%b want 1 0 0 0 0",
        if16.in_ready, if16.out_valid, if16.COUT, if16.OVF, if16.ZERO); end
  endtask

  task automatic test_carry;
    int l8, l16, l32;
    logic [63:0] s8, s16, s32;
    logic c16, o16, z16;
    do_reset();
    l8 = 0; l16 = 0; l32 = 0; s8 = '0; s16 = '0; s32 = '0; c16 = 1'b0; o16 = 1'b0; z16 = 1'b0;
    tb_a = 64'h0000_0000_FFFF_FFFF; tb_b = 64'd1; tb_sub = 1'b0; tb_cin = 1'b0;
    tb_in_valid = 1'b1; tb_out_ready = 1'b1;
    @(posedge clk); #1;
    tb_in_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (if8.out_valid && l8 == 0) begin l8 = c; s8 = if8.S; end
      if (if32.out_valid && l32 == 0) begin l32 = c; s32 = if32.S; end
      if (if16.out_valid && l16 == 0) begin
        l16 = c; s16 = if16.S; c16 = if16.COUT; o16 = if16.OVF; z16 = if16.ZERO;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (l16 != 4) begin n_fail++; $display("FAIL carry_lat16: got %0d want 4", l16); end
    n_cmp++; if (l8 != 8) begin n_fail++; $display("FAIL carry_lat8: got %0d want 8", l8); end
    n_cmp++; if (l32 != 2) begin n_fail++; $display("FAIL carry_lat32: got %0d want 2", l32); end
    n_cmp++; if (s16 !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL carry_s16: got %h want 0000000100000000", s16); end
    n_cmp++; if (s8 !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL carry_s8: got %h want 0000000100000000", s8); end
    n_cmp++; if (s32 !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL carry_s32: got %h want 0000000100000000", s32); end
    n_cmp++; if ({c16, o16, z16} !== 3'b000) begin n_fail++; $display("FAIL carry_flags: got cout/ovf/zero=%b want 000", {c16, o16, z16}); end
  endtask

  task automatic test_sub;
    logic [63:0] s; logic c, o, z; int lat;
    do_reset();
    run_one(64'd5, 64'd7, 1'b1, 1'b0, s, c, o, z, lat);
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL sub_lat: got %0d want 4", lat); end
    n_cmp++; if (s !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL sub_5m7_s: got %h want fffffffffffffffe", s); end
    n_cmp++; if ({c, o, z} !== 3'b000) begin n_fail++; $display("FAIL sub_5m7_flags: got %b want 000", {c, o, z}); end
    run_one(64'd7, 64'd7, 1'b1, 1'b0, s, c, o, z, lat);
    n_cmp++; if (s !== 64'd0) begin n_fail++; $display("FAIL sub_7m7_s: got %h want 0", s); end
    n_cmp++; if ({c, o, z} !== 3'b101) begin n_fail++; $display("FAIL sub_7m7_flags: got %b want 101", {c, o, z}); end
    run_one(64'd5, 64'd3, 1'b1, 1'b1, s, c, o, z, lat);
    n_cmp++; if (s !== 64'd1 || c !== 1'b1) begin n_fail++; $display("FAIL sub_borrowin: got s=%h c=%b want 1 1", s, c); end
    run_one(64'd1, 64'd2, 1'b0, 1'b1, s, c, o, z, lat);
    n_cmp++; if (s !== 64'd4 || c !== 1'b0) begin n_fail++; $display("FAIL add_cin: got s=%h c=%b want 4 0", s, c); end
  endtask

  task automatic test_ovf;
    logic [63:0] s; logic c, o, z; int lat;
    do_reset();
    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, s, c, o, z, lat);
    n_cmp++; if (s !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL ovf_pos_s: got %h want 8000000000000000", s); end
    n_cmp++; if ({c, o, z} !== 3'b010) begin n_fail++; $display("FAIL ovf_pos_flags: got %b want 010", {c, o, z}); end
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, s, c, o, z, lat);
    n_cmp++; if (s !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL wrap_s: got %h want fffffffffffffffe", s); end
    n_cmp++; if ({c, o, z} !== 3'b100) begin n_fail++; $display("FAIL wrap_flags: got %b want 100", {c, o, z}); end
    run_one(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, s, c, o, z, lat);
    n_cmp++; if (s !== 64'h7FFF_FFFF_FFFF_FFFF || {c, o, z} !== 3'b110) begin n_fail++;
      $display("FAIL ovf_neg: got s=%h flags=%b want 7fffffffffffffff 110", s, {c, o, z}); end
  endtask

  task automatic test_backpressure;
    logic [63:0] va [16];
    logic [63:0] vb [16];
    logic        vs [16];
    logic        vc [16];
    logic [65:0] exp_r;
    logic [63:0] held_s;
    logic        held_c, held_o, held_z, held;
    bit   [3:0]  pat;
    int          in_idx, out_idx, cyc, extra;
    pat = 4'b1001;
    for (int i = 0; i < 16; i++) begin
      va[i] = {$urandom(), $urandom()};
      vb[i] = {$urandom(), $urandom()};
      vs[i] = 1'($urandom_range(1));
      vc[i] = 1'($urandom_range(1));
    end
    do_reset();
    held = 1'b0; held_s = '0; held_c = 1'b0; held_o = 1'b0; held_z = 1'b0;
    in_idx = 0; out_idx = 0; cyc = 0;
    while (out_idx < 16 && cyc < 300) begin
      tb_out_ready = pat[cyc % 4];
      if (in_idx < 16) begin
        tb_in_valid = 1'b1; tb_a = va[in_idx]; tb_b = vb[in_idx]; tb_sub = vs[in_idx]; tb_cin = vc[in_idx];
      end else begin
        tb_in_valid = 1'b0;
      end
      @(negedge clk);
      if (held) begin
        n_cmp++;
        if (if16.out_valid !== 1'b1 || if16.S !== held_s || if16.COUT !== held_c || if16.OVF !== held_o || if16.ZERO !== held_z)
          begin n_fail++; $display("FAIL stall_hold cyc%0d: got vld=%b s=%h want 1 %h", cyc, if16.out_valid, if16.S, held_s); end
      end
      if (if16.out_valid === 1'b1) begin
        if (tb_out_ready) begin
          exp_r = model(va[out_idx], vb[out_idx], vs[out_idx], vc[out_idx]);
          n_cmp++;
          if ({if16.OVF, if16.COUT, if16.S} !== exp_r || if16.ZERO !== (exp_r[63:0] == 64'd0))
            begin n_fail++; $display("FAIL bp_beat%0d: got ovf/cout/s=%b/%b/%h want %b/%b/%h", out_idx,
              if16.OVF, if16.COUT, if16.S, exp_r[65], exp_r[64], exp_r[63:0]); end
          out_idx++;
          held = 1'b0;
        end else begin
          held = 1'b1; held_s = if16.S; held_c = if16.COUT; held_o = if16.OVF; held_z = if16.ZERO;
        end
      end else begin
        held = 1'b0;
      end
      if (tb_in_valid && if16.in_ready) in_idx++;
      @(posedge clk); #1;
      cyc++;
    end
    tb_in_valid = 1'b0; tb_out_ready = 1'b1;
    n_cmp++; if (out_idx != 16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", out_idx); end
    extra = 0;
    repeat (8) begin
      if (if16.out_valid) extra++;
      @(posedge clk); #1;
    end
    n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL bp_dup: got %0d extra want 0", extra); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a_v [8] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_FFFF_0000_FFFF, 64'h8000_0000_0000_0000,
                             64'h1234_5678_9ABC_DEF0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_0000_FFFF_0000};
    logic [63:0] b_v [8] = '{64'h1, 64'h1, 64'h1, 64'h1, 64'h0FED_CBA9_8765_4321, 64'h0,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'h0001_0000_0001_0000};
    logic        s_v [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        c_v [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [65:0] exp_r;
    int first, last, oidx;
    do_reset();
    tb_out_ready = 1'b1; first = -1; last = -1; oidx = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 8) begin
        tb_in_valid = 1'b1; tb_a = a_v[cyc]; tb_b = b_v[cyc]; tb_sub = s_v[cyc]; tb_cin = c_v[cyc];
        n_cmp++;
        if (if16.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cyc%0d: got %b want 1", cyc, if16.in_ready); end
      end else begin
        tb_in_valid = 1'b0;
      end
      if (if16.out_valid === 1'b1 && oidx < 8) begin
        exp_r = model(a_v[oidx], b_v[oidx], s_v[oidx], c_v[oidx]);
        n_cmp++;
        if ({if16.OVF, if16.COUT, if16.S} !== exp_r) begin n_fail++;
          $display("FAIL b2b_beat%0d: got %b/%b/%h want %b/%b/%h", oidx, if16.OVF, if16.COUT, if16.S,
            exp_r[65], exp_r[64], exp_r[63:0]); end
        if (first < 0) first = cyc;
        last = cyc;
        oidx++;
      end else if (if16.out_valid === 1'b1) begin
        oidx++;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (oidx != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", oidx); end
    n_cmp++; if (first != 4 || last != 11) begin n_fail++; $display("FAIL b2b_timing: got first=%0d last=%0d want 4 11", first, last); end
  endtask

  task automatic test_midflight_reset;
    int v8, v16, v32;
    do_reset();
    tb_out_ready = 1'b1; tb_a = 64'd3; tb_b = 64'd4; tb_sub = 1'b0; tb_cin = 1'b0;
    v8 = 0; v16 = 0; v32 = 0;
    tb_in_valid = 1'b1;
    @(posedge clk); #1;
    tb_in_valid = 1'b0; rst = 1'b1;
    if (if32.out_valid) v32++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (if8.out_valid) v8++;
      if (if16.out_valid) v16++;
      if (if32.out_valid) v32++;
      @(posedge clk); #1;
    end
    n_cmp++; if (v32 != 0) begin n_fail++; $display("FAIL midrst_seg32: got %0d beats want 0", v32); end
    do_reset();
    v8 = 0; v16 = 0;
    for (int i = 0; i < 3; i++) begin
      tb_in_valid = 1'b1; tb_a = 64'(i + 10); tb_b = 64'd1;
      @(posedge clk); #1;
      if (if8.out_valid) v8++;
      if (if16.out_valid) v16++;
    end
    tb_in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (if8.out_valid) v8++;
      if (if16.out_valid) v16++;
      @(posedge clk); #1;
    end
    n_cmp++; if (v8 != 0) begin n_fail++; $display("FAIL midrst_seg8: got %0d beats want 0", v8); end
    n_cmp++; if (v16 != 0) begin n_fail++; $display("FAIL midrst_seg16: got %0d beats want 0", v16); end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_sub();
    test_ovf();
    test_backpressure();
    test_back_to_back();
    test_midflight_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
